// File: rtl/dnn_layer_master.sv
// Avalon-MM master that evaluates one dense layer held in SDRAM:
// out[i] = act(bias[i] + sum_j W[i][j] * activ[j]) in signed fixed point.
module dnn_layer_master #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FRAC_BITS = 16,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ACC_W     = 64,
  parameter int unsigned LEN_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] bias_v_addr,
  input  logic [ADDR_W-1:0] weight_m_addr,
  input  logic [ADDR_W-1:0] activ_addr,
  input  logic [ADDR_W-1:0] out_activ_addr,
  input  logic [LEN_W-1:0]  activ_len,
  input  logic [LEN_W-1:0]  out_len,
  input  logic              relu,
  input  logic              master_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_readdatavalid,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata
);

  localparam logic [ADDR_W-1:0] Stride = ADDR_W'(DATA_W / 8);

  typedef enum logic [3:0] {
    StIdle, StRdBias, StWtBias, StRdW, StWtW, StRdA, StWtA, StMac, StWr, StDone
  } state_e;

  state_e                    state_q, state_d;
  logic [LEN_W-1:0]          i_q, i_d, j_q, j_d;
  logic [LEN_W-1:0]          i_inc, j_inc;
  logic [LEN_W-1:0]          activ_len_q, activ_len_d, out_len_q, out_len_d;
  logic                      relu_q, relu_d;
  logic [ADDR_W-1:0]         bias_ptr_q, bias_ptr_d, w_ptr_q, w_ptr_d;
  logic [ADDR_W-1:0]         a_base_q, a_base_d, a_ptr_q, a_ptr_d;
  logic [ADDR_W-1:0]         out_ptr_q, out_ptr_d;
  logic signed [DATA_W-1:0]  w_q, w_d, a_q, a_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod, prod_sh;
  logic signed [ACC_W-1:0]   mac_term, bias_ext;
  logic [DATA_W-1:0]         wr_data;

  // Full-width signed product, rescaled back to the fixed-point format.
  assign prod     = (2*DATA_W)'(w_q) * (2*DATA_W)'(a_q);
  assign prod_sh  = prod >>> FRAC_BITS;
  assign mac_term = ACC_W'(prod_sh);
  assign bias_ext = ACC_W'(signed'(master_readdata));
  assign i_inc    = i_q + LEN_W'(1);
  assign j_inc    = j_q + LEN_W'(1);
  assign wr_data  = (relu_q && acc_q[ACC_W-1]) ? '0 : acc_q[DATA_W-1:0];

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    activ_len_d = activ_len_q;
    out_len_d   = out_len_q;
    relu_d      = relu_q;
    bias_ptr_d  = bias_ptr_q;
    w_ptr_d     = w_ptr_q;
    a_base_d    = a_base_q;
    a_ptr_d     = a_ptr_q;
    out_ptr_d   = out_ptr_q;
    w_d         = w_q;
    a_d         = a_q;
    acc_d       = acc_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          activ_len_d = activ_len;
          out_len_d   = out_len;
          relu_d      = relu;
          bias_ptr_d  = bias_v_addr;
          w_ptr_d     = weight_m_addr;
          a_base_d    = activ_addr;
          out_ptr_d   = out_activ_addr;
          i_d         = '0;
          state_d     = (out_len == '0) ? StDone : StRdBias;
        end
      end
      StRdBias: if (!master_waitrequest) state_d = StWtBias;
      StWtBias: begin
        if (master_readdatavalid) begin
          acc_d   = bias_ext;
          j_d     = '0;
          a_ptr_d = a_base_q;
          state_d = (activ_len_q == '0) ? StWr : StRdW;
        end
      end
      StRdW: if (!master_waitrequest) state_d = StWtW;
      StWtW: begin
        if (master_readdatavalid) begin
          w_d     = signed'(master_readdata);
          w_ptr_d = w_ptr_q + Stride;
          state_d = StRdA;
        end
      end
      StRdA: if (!master_waitrequest) state_d = StWtA;
      StWtA: begin
        if (master_readdatavalid) begin
          a_d     = signed'(master_readdata);
          a_ptr_d = a_ptr_q + Stride;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d   = acc_q + mac_term;
        j_d     = j_inc;
        state_d = (j_inc == activ_len_q) ? StWr : StRdW;
      end
      StWr: begin
        if (!master_waitrequest) begin
          i_d        = i_inc;
          bias_ptr_d = bias_ptr_q + Stride;
          out_ptr_d  = out_ptr_q + Stride;
          state_d    = (i_inc == out_len_q) ? StDone : StRdBias;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    master_read      = 1'b0;
    master_write     = 1'b0;
    master_address   = '0;
    master_writedata = '0;
    unique case (state_q)
      StIdle: ;
      StDone: done = 1'b1;
      StRdBias: begin
        busy           = 1'b1;
        master_read    = 1'b1;
        master_address = bias_ptr_q;
      end
      StRdW: begin
        busy           = 1'b1;
        master_read    = 1'b1;
        master_address = w_ptr_q;
      end
      StRdA: begin
        busy           = 1'b1;
        master_read    = 1'b1;
        master_address = a_ptr_q;
      end
      StWr: begin
        busy             = 1'b1;
        master_write     = 1'b1;
        master_address   = out_ptr_q;
        master_writedata = wr_data;
      end
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      i_q         <= '0;
      j_q         <= '0;
      activ_len_q <= '0;
      out_len_q   <= '0;
      relu_q      <= 1'b0;
      bias_ptr_q  <= '0;
      w_ptr_q     <= '0;
      a_base_q    <= '0;
      a_ptr_q     <= '0;
      out_ptr_q   <= '0;
      w_q         <= '0;
      a_q         <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      activ_len_q <= activ_len_d;
      out_len_q   <= out_len_d;
      relu_q      <= relu_d;
      bias_ptr_q  <= bias_ptr_d;
      w_ptr_q     <= w_ptr_d;
      a_base_q    <= a_base_d;
      a_ptr_q     <= a_ptr_d;
      out_ptr_q   <= out_ptr_d;
      w_q         <= w_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
    end
  end

endmodule

// File: tb/tb_dnn_layer_master.sv
// Bench for dnn_layer_master: memory-backed Avalon slave, write scoreboard and
// directed layers with hand-computed fixed-point results.
module tb_dnn_layer_master;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, relu;
  logic [31:0] bias_v_addr, weight_m_addr, activ_addr, out_activ_addr;
  logic [15:0] activ_len, out_len;
  logic        master_waitrequest, master_read, master_readdatavalid, master_write;
  logic [31:0] master_address, master_readdata, master_writedata;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  bit bp = 1'b0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];

  always #5 clk = ~clk;

  dnn_layer_master dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .busy                 (busy),
    .done                 (done),
    .bias_v_addr          (bias_v_addr),
    .weight_m_addr        (weight_m_addr),
    .activ_addr           (activ_addr),
    .out_activ_addr       (out_activ_addr),
    .activ_len            (activ_len),
    .out_len              (out_len),
    .relu                 (relu),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  // Slave: decides waitrequest/readdatavalid just after each edge for the next edge.
  initial begin : slave
    bit          pend_valid = 1'b0;
    int          pend_delay = 0;
    int          stall = 0;
    bit          armed = 1'b0;
    logic [31:0] pend_data = '0;
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = 32'hBAD0_0000;
    forever begin
      @(posedge clk);
      #1;
      master_readdatavalid = 1'b0;
      master_readdata      = 32'hBAD0_0000;
      if (rst) begin
        pend_valid = 1'b0;
        armed = 1'b0;
        master_waitrequest = 1'b0;
      end else begin
        if (master_read) chk("one_outstanding", {63'd0, pend_valid}, 64'd0);
        if (pend_valid) begin
          if (pend_delay == 0) begin
            master_readdatavalid = 1'b1;
            master_readdata      = pend_data;
            pend_valid           = 1'b0;
          end else begin
            pend_delay--;
          end
        end
        if (master_read || master_write) begin
          if (!armed) begin
            stall = bp ? $urandom_range(0, 4) : 0;
            armed = 1'b1;
          end
          if (stall > 0) begin
            master_waitrequest = 1'b1;
            stall--;
          end else begin
            master_waitrequest = 1'b0;
            armed = 1'b0;
          end
        end else begin
          master_waitrequest = bp ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (master_read && !master_waitrequest) begin
          pend_valid = 1'b1;
          pend_delay = bp ? $urandom_range(0, 5) : 0;
          pend_data  = mem.exists(master_address) ? mem[master_address] : 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Monitor: protocol checks and write scoreboard, sampled mid-cycle.
  initial begin : monitor
    bit          prev_rstall = 1'b0;
    bit          prev_wstall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic [31:0] ea, ed;
    forever begin
      @(negedge clk);
      chk("rd_wr_exclusive", {63'd0, master_read && master_write}, 64'd0);
      if (prev_rstall) begin
        chk("read_held", {63'd0, master_read}, 64'd1);
        chk("read_addr_stable", {32'd0, master_address}, {32'd0, prev_addr});
      end
      if (prev_wstall) begin
        chk("write_held", {63'd0, master_write}, 64'd1);
        chk("write_addr_stable", {32'd0, master_address}, {32'd0, prev_addr});
        chk("write_data_stable", {32'd0, master_writedata}, {32'd0, prev_data});
      end
      if (master_read && !master_waitrequest) rd_cnt++;
      if (master_write && !master_waitrequest) begin
        wr_cnt++;
        if (exp_data_q.size() == 0) begin
          chk("unexpected_write_addr", {32'd0, master_address}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          chk("write_addr", {32'd0, master_address}, {32'd0, ea});
          chk("write_data", {32'd0, master_writedata}, {32'd0, ed});
        end
      end
      prev_rstall = master_read && master_waitrequest;
      prev_wstall = master_write && master_waitrequest;
      prev_addr   = master_address;
      prev_data   = master_writedata;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cfg(input logic [31:0] b, w, a, o, input logic [15:0] al, ol,
                     input logic r);
    bias_v_addr = b; weight_m_addr = w; activ_addr = a; out_activ_addr = o;
    activ_len = al; out_len = ol; relu = r;
  endtask

  task automatic expect_wr(input logic [31:0] a, d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  // Pulse start, count busy cycles until done; disturb pokes start and config mid-layer.
  task automatic run_layer(input string name, input int exp_busy, input bit disturb,
                           output int done_cyc);
    int busy_cnt = 0;
    int cyc = 0;
    bit seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
        chk({name, "_busy_low_at_done"}, {63'd0, busy}, 64'd0);
        if (disturb) start = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if (disturb && cyc == 5) begin
          start = 1'b1;
          cfg(32'hDEAD_0000, 32'hDEAD_1000, 32'hDEAD_2000, 32'hDEAD_3000, 16'd7, 16'd5, 1'b1);
        end
      end
    end
    chk({name, "_done_seen"}, {63'd0, seen}, 64'd1);
    if (!seen) done_cyc = -1;
    if (exp_busy >= 0) chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    @(negedge clk);
    start = 1'b0;
    chk({name, "_done_one_cycle"}, {62'd0, done, busy}, 64'd0);
    repeat (3) @(negedge clk);
    chk({name, "_idle_after"}, {63'd0, busy}, 64'd0);
    chk({name, "_all_writes_seen"}, 64'(exp_data_q.size()), 64'd0);
  endtask

  initial begin : main
    int dc, rd0, wr0;
    bit found, saw_done;
    rst = 1'b1;
    start = 1'b0;
    cfg('0, '0, '0, '0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_read", {63'd0, master_read}, 64'd0);
    chk("rst_write", {63'd0, master_write}, 64'd0);
    chk("rst_address", {32'd0, master_address}, 64'd0);
    chk("rst_writedata", {32'd0, master_writedata}, 64'd0);

    // 0.5 + 2.0*1.0 + 1.0*3.0 = 5.5
    mem[32'h1000] = 32'h0000_8000;
    mem[32'h2000] = 32'h0002_0000; mem[32'h2004] = 32'h0001_0000;
    mem[32'h3000] = 32'h0001_0000; mem[32'h3004] = 32'h0003_0000;
    cfg(32'h1000, 32'h2000, 32'h3000, 32'h4000, 16'd2, 16'd1, 1'b0);
    expect_wr(32'h4000, 32'h0005_8000);
    run_layer("basic", 13, 1'b1, dc);

    // -1.0 + 1.0*0.5 = -0.5, then clamped by ReLU
    mem[32'h1100] = 32'hFFFF_0000;
    mem[32'h2100] = 32'h0001_0000;
    mem[32'h3100] = 32'h0000_8000;
    cfg(32'h1100, 32'h2100, 32'h3100, 32'h4100, 16'd1, 16'd1, 1'b0);
    expect_wr(32'h4100, 32'hFFFF_8000);
    run_layer("relu_off", 8, 1'b0, dc);
    cfg(32'h1100, 32'h2100, 32'h3100, 32'h4100, 16'd1, 16'd1, 1'b1);
    expect_wr(32'h4100, 32'h0000_0000);
    run_layer("relu_on", 8, 1'b0, dc);

    mem[32'h1200] = 32'h0000_0003; mem[32'h1204] = 32'hFFFF_FFFD;
    cfg(32'h1200, 32'h2200, 32'h3200, 32'h0100, 16'd0, 16'd2, 1'b1);
    expect_wr(32'h0100, 32'h0000_0003);
    expect_wr(32'h0104, 32'h0000_0000);
    rd0 = rd_cnt;
    run_layer("alen0", 6, 1'b0, dc);
    chk("alen0_reads", 64'(rd_cnt - rd0), 64'd2);

    // 3x4 layer: rows evaluate to 2.5, -0.5, -0.25
    mem[32'h1300] = 32'h0000_0000; mem[32'h1304] = 32'h0001_0000; mem[32'h1308] = 32'hFFFF_C000;
    mem[32'h2300] = 32'h0001_0000; mem[32'h2304] = 32'h0001_0000;
    mem[32'h2308] = 32'h0001_0000; mem[32'h230C] = 32'h0001_0000;
    mem[32'h2310] = 32'h0000_8000; mem[32'h2314] = 32'hFFFF_0000;
    mem[32'h2318] = 32'h0002_0000; mem[32'h231C] = 32'h0004_0000;
    mem[32'h2320] = 32'hFFFE_0000; mem[32'h2324] = 32'h0000_4000;
    mem[32'h2328] = 32'h0000_0000; mem[32'h232C] = 32'h0003_0000;
    mem[32'h3300] = 32'h0001_0000; mem[32'h3304] = 32'h0002_0000;
    mem[32'h3308] = 32'hFFFF_0000; mem[32'h330C] = 32'h0000_8000;
    for (int k = 0; k < 3; k++) begin
      cfg(32'h1300, 32'h2300, 32'h3300, 32'h5000, 16'd4, 16'd3, 1'b0);
      expect_wr(32'h5000, 32'h0002_8000);
      expect_wr(32'h5004, 32'hFFFF_8000);
      expect_wr(32'h5008, 32'hFFFF_C000);
      bp = (k != 0);
      run_layer(k == 0 ? "l3x4_ideal" : "l3x4_bp", k == 0 ? 69 : -1, 1'b0, dc);
    end
    bp = 1'b0;

    // Abort during the first weight wait, then run a fresh layer.
    cfg(32'h1000, 32'h2000, 32'h3000, 32'h4000, 16'd2, 16'd1, 1'b0);
    wr0 = wr_cnt;
    found = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (master_read && master_address == 32'h2000) found = 1'b1;
    end
    chk("abort_reached_weight_read", {63'd0, found}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_read", {63'd0, master_read}, 64'd0);
    chk("abort_write", {63'd0, master_write}, 64'd0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_stays_idle", {63'd0, saw_done}, 64'd0);
    chk("abort_no_writes", 64'(wr_cnt - wr0), 64'd0);
    cfg(32'h1100, 32'h2100, 32'h3100, 32'h4200, 16'd1, 16'd1, 1'b0);
    expect_wr(32'h4200, 32'hFFFF_8000);
    run_layer("after_abort", 8, 1'b0, dc);

    cfg(32'h1000, 32'h2000, 32'h3000, 32'h4000, 16'd3, 16'd0, 1'b0);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    run_layer("olen0", 0, 1'b0, dc);
    chk("olen0_done_latency", 64'(dc), 64'd1);
    chk("olen0_no_reads", 64'(rd_cnt - rd0), 64'd0);
    chk("olen0_no_writes", 64'(wr_cnt - wr0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dnn_layer_master.md
Name: dnn_layer_master

Overview:
Avalon-MM bus master that evaluates one full dense layer in SDRAM: out[i] = act(bias[i] + sum_j W[i][j]*activ[j]) for i in 0..out_len-1.
Generalises the single-neuron DNN master with a parametrised data width, fixed-point format, output-vector length and optional ReLU.
Sits between the CPU-facing parameter/control registers and the SDRAM interconnect.

Parameters:
DATA_W, 32, word width of bias, weight, activation and result (signed two's complement)
FRAC_BITS, 16, fractional bits of the fixed-point format
ADDR_W, 32, byte-address width; word stride is DATA_W/8
ACC_W, 64, accumulator width (must be >= DATA_W)
LEN_W, 16, width of the activ_len and out_len counters

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin a layer (sampled in IDLE only)
busy  out  1  layer in progress
done  out  1  one-cycle pulse when the layer completes
bias_v_addr  in  ADDR_W  byte base address of the bias vector
weight_m_addr  in  ADDR_W  byte base address of the row-major weight matrix
activ_addr  in  ADDR_W  byte base address of the input activations
out_activ_addr  in  ADDR_W  byte base address of the output activations
activ_len  in  LEN_W  input vector length
out_len  in  LEN_W  output vector length
relu  in  1  apply ReLU when 1
master_waitrequest  in  1  Avalon stall
master_address  out  ADDR_W  byte address
master_read  out  1  read request
master_readdata  in  DATA_W  read data
master_readdatavalid  in  1  read data valid
master_write  out  1  write request
master_writedata  out  DATA_W  write data

Behaviour:
- One clock; reset is synchronous and active-high. rst=1 drives the following on the next edge: state=IDLE, busy=0, done=0, master_read=0, master_write=0, master_address=0, master_writedata=0.
- Reset mid-operation aborts the layer immediately. No further bus requests are issued. readdatavalid for an abandoned read is ignored.
- States: IDLE, RD_BIAS, WT_BIAS, RD_W, WT_W, RD_A, WT_A, MAC, WR, DONE.
- IDLE: on start=1, snapshot all config inputs, set busy=1 and clear i. If out_len=0, go to DONE; otherwise go to RD_BIAS. Config changes after the snapshot have no effect.
- RD_BIAS reads bias_v_addr + i*S (S = DATA_W/8). WT_BIAS loads acc = sign-extended bias and clears j. If activ_len=0, go to WR; otherwise go to RD_W.
- RD_W reads the weight at a running pointer. The pointer starts at weight_m_addr and advances by S after each weight read, so no multiply is needed. WT_W latches the weight.
- RD_A reads activ_addr + j*S. WT_A latches the activation.
- MAC: acc += (W*A signed full 2*DATA_W product) >>> FRAC_BITS (arithmetic shift). The accumulator wraps modulo 2^ACC_W. Then j++. If j = activ_len, go to WR; otherwise go to RD_W.
- WR: writedata = (relu && acc<0) ? 0 : acc[DATA_W-1:0], truncated with no saturation. Address = out_activ_addr + i*S. Then i++. If i = out_len, go to DONE; otherwise go to RD_BIAS.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Read handshake: master_read=1 with a stable address until a cycle with waitrequest=0 (accept). read drops the next cycle. The RD_* state moves to its WT_* state on accept. The WT_* state holds until readdatavalid=1 and captures readdata that cycle.
- At most one read is outstanding. readdatavalid outside WT_* states is ignored.
- Write handshake: master_write=1 with stable address and data until waitrequest=0. write drops the next cycle.
- read and write are never asserted together.
- start while busy or in DONE is ignored.
- Address arithmetic wraps modulo 2^ADDR_W.
- Ideal-slave latency: waitrequest=0 and readdatavalid one cycle after accept. Under that slave, busy is high for exactly out_len*(3+5*activ_len) cycles, then the done pulse follows.

Test Plan:
- Basic MAC (FRAC_BITS=16, activ_len=2, out_len=1, relu=0): bias=0x00008000, W=[0x00020000,0x00010000], A=[0x00010000,0x00030000] -> one write 0x00058000 at out_activ_addr; busy for 13 cycles; one done pulse.
- ReLU (bias=0xFFFF0000, W=[0x00010000], A=[0x00008000]): relu=0 -> writes 0xFFFF8000; relu=1 -> writes 0x00000000.
- Multi-output, activ_len=0 (out_len=2, bias=[0x00000003,0xFFFFFFFD], relu=1, out_activ_addr=0x100): reads only the two biases; writes 0x3 at 0x100 and 0x0 at 0x104.
- Back-pressure (random waitrequest 0-4 cycles, readdatavalid delayed 1-6 cycles, 3x4 layer): identical results to the ideal-slave run. Address, read, write and writedata stay stable while stalled. Never more than one read outstanding.
- Reset mid-layer (rst=1 during WT_W): next cycle busy=0, read=0, write=0, with no done pulse and no writes. A later start with new config completes correctly.
- Control edges: out_len=0 -> done pulse 1 cycle after start with no bus activity. start pulsed while busy -> ignored. Config inputs changed mid-layer -> results match the snapshot.
